// File: rtl/collision_pkg.sv
// Shared types and constants for the collision event scheduler.
package collision_pkg;

  typedef enum logic {
    ARB_IDLE    = 1'b0,
    ARB_PRESENT = 1'b1
  } arb_state_t;

  // Object layer indices as wired into drawing_request_obj
  localparam int SRC_WALL          = 0;
  localparam int SRC_PLATFORM      = 1;
  localparam int SRC_TRANSPLATFORM = 2;
  localparam int SRC_BONUS         = 3;

  localparam int N_SRC_DEFAULT = 4;

  // Cooldown counter width; one bit minimum so a zero holdoff still builds
  function automatic int cd_width(input int holdoff);
    return (holdoff > 0) ? $clog2(holdoff + 1) : 1;
  endfunction

endpackage

// File: rtl/collision_cooldown.sv
// Per-source frame-down counter: muted while non-zero after an ack.
module collision_cooldown #(
  parameter int HOLDOFF_FRAMES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic tick,
  output logic muted
);
  import collision_pkg::*;

  localparam int CW = cd_width(HOLDOFF_FRAMES);

  logic [CW-1:0] cnt_q, cnt_d;

  // Load wins over the frame tick so an ack on a frame edge gets the full holdoff
  always_comb begin
    cnt_d = cnt_q;
    if (load)                     cnt_d = CW'(HOLDOFF_FRAMES);
    else if (tick && cnt_q != '0) cnt_d = cnt_q - 1'b1;
  end

  // Counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign muted = (cnt_q != '0);

endmodule

// File: rtl/collision_event_scheduler.sv
// Frame-based collision collector: accumulates bumpy/object overlaps per source,
// snapshots them at frame start into pending events, and serves them one at a
// time (fixed priority, source 0 highest) over a valid/ack handshake.
module collision_event_scheduler #(
  parameter int N_SRC          = collision_pkg::N_SRC_DEFAULT,
  parameter int HOLDOFF_FRAMES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     startOfFrame,
  input  logic                     drawing_request_bumpy,
  input  logic [N_SRC-1:0]         drawing_request_obj,
  output logic                     event_valid,
  output logic [$clog2(N_SRC)-1:0] event_id,
  input  logic                     event_ack,
  output logic [N_SRC-1:0]         pending,
  output logic                     overrun
);
  import collision_pkg::*;

  localparam int IDW = $clog2(N_SRC);

  arb_state_t       state_q, state_d;
  logic [IDW-1:0]   event_id_q, event_id_d;
  logic [N_SRC-1:0] hit_acc_q, hit_acc_d;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic             overrun_q, overrun_d;

  logic [N_SRC-1:0] hit, snap, ack_mask, muted, drop;
  logic [IDW-1:0]   lowest;
  logic             ack_fire;

  assign hit      = drawing_request_bumpy ? drawing_request_obj : '0;
  assign ack_fire = event_ack && (state_q == ARB_PRESENT);

  // Per-source holdoff counters, reloaded when that source is acked
  for (genvar g = 0; g < N_SRC; g++) begin : g_cd
    collision_cooldown #(.HOLDOFF_FRAMES(HOLDOFF_FRAMES)) u_cd (
      .clk   (clk),
      .reset (reset),
      .load  (ack_mask[g]),
      .tick  (startOfFrame),
      .muted (muted[g])
    );
  end

  // Accumulate hits, snapshot at frame start, merge into pending, flag overruns
  always_comb begin
    ack_mask = '0;
    if (ack_fire) ack_mask[event_id_q] = 1'b1;
    snap      = startOfFrame ? (hit_acc_q | hit) : '0;
    hit_acc_d = startOfFrame ? '0 : (hit_acc_q | hit);
    // The source being acked is treated as muted so its own snapshot is dropped
    drop      = muted | ack_mask;
    pending_d = (pending_q & ~ack_mask) | (snap & ~drop);
    overrun_d = |(snap & pending_q & ~ack_mask);
  end

  // Fixed-priority encoder: lowest set pending index
  always_comb begin
    lowest = '0;
    for (int i = N_SRC - 1; i >= 0; i--)
      if (pending_q[i]) lowest = IDW'(i);
  end

  // Arbiter next-state: present one event and hold it until acked
  always_comb begin
    state_d    = state_q;
    event_id_d = event_id_q;
    case (state_q)
      ARB_IDLE: begin
        if (pending_q != '0) begin
          event_id_d = lowest;
          state_d    = ARB_PRESENT;
        end
      end
      ARB_PRESENT: begin
        if (event_ack) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ARB_IDLE;
      event_id_q <= '0;
      hit_acc_q  <= '0;
      pending_q  <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      event_id_q <= event_id_d;
      hit_acc_q  <= hit_acc_d;
      pending_q  <= pending_d;
      overrun_q  <= overrun_d;
    end
  end

  assign event_valid = (state_q == ARB_PRESENT);
  assign event_id    = event_id_q;
  assign pending     = pending_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_collision_event_scheduler.sv
// Directed bench for collision_event_scheduler (N_SRC=4, HOLDOFF_FRAMES=2).
module tb_collision_event_scheduler;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         sof;
  logic         bumpy;
  logic [N-1:0] obj;
  logic         ack;
  logic         event_valid;
  logic [1:0]   event_id;
  logic [N-1:0] pending;
  logic         overrun;

  int checks   = 0;
  int failures = 0;
  int ovr_seen = 0;

  always #5 clk = ~clk;

  collision_event_scheduler #(.N_SRC(N), .HOLDOFF_FRAMES(2)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .startOfFrame          (sof),
    .drawing_request_bumpy (bumpy),
    .drawing_request_obj   (obj),
    .event_valid           (event_valid),
    .event_id              (event_id),
    .event_ack             (ack),
    .pending               (pending),
    .overrun               (overrun)
  );

  // One clock edge; outputs are sampled 1ns after it
  task automatic step();
    @(posedge clk);
    #1;
    if (overrun === 1'b1) ovr_seen++;
  endtask

  task automatic idle_inputs();
    sof = 0; bumpy = 0; obj = '0; ack = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    step();
    step();
    reset = 0;
    ovr_seen = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (event_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", event_valid); end
    checks++; if (event_id !== 2'd0) begin failures++; $display("FAIL reset_id got=%0d exp=0", event_id); end
    checks++; if (pending !== 4'b0000) begin failures++; $display("FAIL reset_pending got=%b exp=0000", pending); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
  endtask

  task automatic test_single_hit();
    do_reset();
    bumpy = 1; obj = 4'b0010;
    repeat (5) step();
    idle_inputs();
    step();
    checks++; if (pending !== 4'b0000) begin failures++; $display("FAIL single_prefr_pending got=%b exp=0000", pending); end
    sof = 1; step(); sof = 0;
    checks++; if (pending !== 4'b0010) begin failures++; $display("FAIL single_pending got=%b exp=0010", pending); end
    checks++; if (event_valid !== 1'b0) begin failures++; $display("FAIL single_valid_s1 got=%b exp=0", event_valid); end
    step();
    checks++; if (event_valid !== 1'b1 || event_id !== 2'd1) begin failures++; $display("FAIL single_present got=%b/%0d exp=1/1", event_valid, event_id); end
    repeat (3) step();
    checks++; if (event_valid !== 1'b1 || event_id !== 2'd1) begin failures++; $display("FAIL single_hold got=%b/%0d exp=1/1", event_valid, event_id); end
    ack = 1; step(); ack = 0;
    checks++; if (event_valid !== 1'b0 || pending !== 4'b0000) begin failures++; $display("FAIL single_ack got=%b/%b exp=0/0000", event_valid, pending); end
  endtask

  task automatic test_priority();
    do_reset();
    bumpy = 1; obj = 4'b0101; step();
    idle_inputs();
    sof = 1; step(); sof = 0;
    checks++; if (pending !== 4'b0101) begin failures++; $display("FAIL prio_pending got=%b exp=0101", pending); end
    step();
    checks++; if (event_valid !== 1'b1 || event_id !== 2'd0) begin failures++; $display("FAIL prio_first got=%b/%0d exp=1/0", event_valid, event_id); end
    ack = 1; step(); ack = 0;
    checks++; if (event_valid !== 1'b0 || pending !== 4'b0100) begin failures++; $display("FAIL prio_ack1 got=%b/%b exp=0/0100", event_valid, pending); end
    step();
    checks++; if (event_valid !== 1'b1 || event_id !== 2'd2) begin failures++; $display("FAIL prio_second got=%b/%0d exp=1/2", event_valid, event_id); end
    ack = 1; step(); ack = 0;
    checks++; if (event_valid !== 1'b0 || pending !== 4'b0000) begin failures++; $display("FAIL prio_ack2 got=%b/%b exp=0/0000", event_valid, pending); end
  endtask

  task automatic test_holdoff();
    logic exp;
    int   nev;
    do_reset();
    nev = 0;
    for (int f = 0; f < 9; f++) begin
      exp = (f % 3 == 0);
      bumpy = 1; obj = 4'b0001; step(); step();
      idle_inputs();
      sof = 1; step(); sof = 0;
      checks++; if (pending !== {3'b000, exp}) begin failures++; $display("FAIL holdoff_pending f=%0d got=%b exp=%b", f, pending, {3'b000, exp}); end
      step();
      checks++; if (event_valid !== exp) begin failures++; $display("FAIL holdoff_valid f=%0d got=%b exp=%b", f, event_valid, exp); end
      if (event_valid === 1'b1) nev++;
      ack = event_valid; step(); ack = 0;
      step();
    end
    checks++; if (nev != 3) begin failures++; $display("FAIL holdoff_events got=%0d exp=3", nev); end
    checks++; if (ovr_seen != 0) begin failures++; $display("FAIL holdoff_overrun got=%0d exp=0", ovr_seen); end
  endtask

  task automatic test_overrun();
    do_reset();
    bumpy = 1; obj = 4'b1000; step();
    idle_inputs();
    sof = 1; step(); sof = 0;
    checks++; if (pending !== 4'b1000 || overrun !== 1'b0) begin failures++; $display("FAIL ovr_f0 got=%b/%b exp=1000/0", pending, overrun); end
    step();
    checks++; if (event_valid !== 1'b1 || event_id !== 2'd3) begin failures++; $display("FAIL ovr_present got=%b/%0d exp=1/3", event_valid, event_id); end
    bumpy = 1; obj = 4'b1000; step();
    idle_inputs();
    sof = 1; step(); sof = 0;
    checks++; if (overrun !== 1'b1 || pending !== 4'b1000) begin failures++; $display("FAIL ovr_pulse got=%b/%b exp=1/1000", overrun, pending); end
    step();
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_width got=%b exp=0", overrun); end
    checks++; if (event_valid !== 1'b1 || event_id !== 2'd3) begin failures++; $display("FAIL ovr_still got=%b/%0d exp=1/3", event_valid, event_id); end
    checks++; if (ovr_seen != 1) begin failures++; $display("FAIL ovr_count got=%0d exp=1", ovr_seen); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    bumpy = 1; obj = 4'b0010; step();
    idle_inputs();
    sof = 1; step(); sof = 0;
    step();
    checks++; if (event_valid !== 1'b1 || event_id !== 2'd1) begin failures++; $display("FAIL simul_present got=%b/%0d exp=1/1", event_valid, event_id); end
    bumpy = 1; obj = 4'b0011; step();
    idle_inputs();
    sof = 1; ack = 1; step(); sof = 0; ack = 0;
    checks++; if (pending !== 4'b0001) begin failures++; $display("FAIL simul_pending got=%b exp=0001", pending); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL simul_overrun got=%b exp=0", overrun); end
    step();
    checks++; if (event_valid !== 1'b1 || event_id !== 2'd0) begin failures++; $display("FAIL simul_next got=%b/%0d exp=1/0", event_valid, event_id); end
    ack = 1; step(); ack = 0;
    // Source 1 should stay muted for exactly two more frame edges
    for (int f = 0; f < 3; f++) begin
      bumpy = 1; obj = 4'b0010; step();
      idle_inputs();
      sof = 1; step(); sof = 0;
      checks++;
      if (pending !== ((f == 2) ? 4'b0010 : 4'b0000)) begin
        failures++; $display("FAIL simul_cooldown f=%0d got=%b exp=%b", f, pending, (f == 2) ? 4'b0010 : 4'b0000);
      end
      step();
    end
  endtask

  task automatic test_sof_hit();
    do_reset();
    bumpy = 1; obj = 4'b1000; sof = 1; step();
    idle_inputs();
    checks++; if (pending !== 4'b1000) begin failures++; $display("FAIL sofhit_pending got=%b exp=1000", pending); end
    step(); step();
    sof = 1; step(); sof = 0;
    checks++; if (overrun !== 1'b0 || pending !== 4'b1000) begin failures++; $display("FAIL sofhit_restart got=%b/%b exp=0/1000", overrun, pending); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bumpy = 1; obj = 4'b0100; step();
    idle_inputs();
    sof = 1; step(); sof = 0;
    step();
    checks++; if (event_valid !== 1'b1) begin failures++; $display("FAIL rstmid_pre got=%b exp=1", event_valid); end
    reset = 1; #1;
    checks++; if ({event_valid, event_id, pending, overrun} !== 8'd0) begin failures++; $display("FAIL rstmid_async got=%b exp=00000000", {event_valid, event_id, pending, overrun}); end
    step();
    reset = 0;
    ovr_seen = 0;
    for (int k = 0; k < 3; k++) begin
      step(); sof = 1; step(); sof = 0;
    end
    step(); step();
    checks++; if (event_valid !== 1'b0 || pending !== 4'b0000 || ovr_seen != 0) begin failures++; $display("FAIL rstmid_noreplay got=%b/%b/%0d exp=0/0000/0", event_valid, pending, ovr_seen); end
    bumpy = 1; obj = 4'b0100; step();
    idle_inputs();
    sof = 1; step(); sof = 0;
    step();
    checks++; if (event_valid !== 1'b1 || event_id !== 2'd2) begin failures++; $display("FAIL rstmid_new got=%b/%0d exp=1/2", event_valid, event_id); end
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    test_reset();
    test_single_hit();
    test_priority();
    test_holdoff();
    test_overrun();
    test_simultaneous();
    test_sof_hit();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
